// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants and the FIFO entry type for the fetch stage
package fetch_stage_pkg;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous {pc, instr} buffer, no bypass, flush beats push
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_wdata,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_rdata,
  output logic         o_full,
  output logic         o_empty,
  output logic [CW-1:0] o_count
);
  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_pop;
  logic          w_push;
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  assign o_rdata = r_mem[r_rp];
  assign w_pop   = i_pop && !o_empty && !i_flush;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign w_push  = i_push && !i_flush && (!o_full || w_pop);
  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_wdata;
  end
  // pointers and occupancy; flush empties the buffer in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= w_push ? r_wp + AW'(1) : r_wp;
      r_rp  <= w_pop ? r_rp + AW'(1) : r_rp;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: fetch PC, credit-limited imem requests, response buffer and decode-facing output registers
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keep,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_pype0,
  output logic [31:0] PCp4_pype0,
  output logic [31:0] Instraction_pype,
  output logic        fetch_nop
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic [31:0]   r_pc;
  logic [31:0]   r_pcp4;
  logic [31:0]   r_instr;
  logic          r_nop;
  logic [31:0]   w_target;
  logic          w_accept;
  logic          w_rvalid;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  assign w_target = redirect_pc & ~32'h3;
  // credit counts in-flight requests plus buffered words; a same-cycle pop is not credited
  assign imem_req = rst && !redirect &&
                    (({1'b0, r_outstanding} + {1'b0, w_count}) < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = r_fetch_pc;
  assign w_accept  = imem_req && imem_ready;
  // a response with nothing outstanding is a protocol error and has no effect
  assign w_rvalid  = imem_rvalid && (r_outstanding != '0);
  assign w_push    = w_rvalid && (r_drop_cnt == '0) && !redirect;
  assign w_pop     = !keep && !redirect && !w_empty;
  assign PC_pype0         = r_pc;
  assign PCp4_pype0       = r_pcp4;
  assign Instraction_pype = r_instr;
  assign fetch_nop        = r_nop;
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_wdata ('{pc: r_resp_pc, instr: imem_rdata}),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  // request/response bookkeeping; on redirect every response still in flight is wrong-path
  // (pending drops are already part of outstanding, so they are covered by the same count)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rvalid);
      if (redirect) begin
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        r_drop_cnt <= r_outstanding - CW'(w_rvalid);
      end else begin
        r_fetch_pc <= w_accept ? r_fetch_pc + 32'd4 : r_fetch_pc;
        r_resp_pc  <= w_push ? r_resp_pc + 32'd4 : r_resp_pc;
        r_drop_cnt <= (w_rvalid && r_drop_cnt != '0) ? r_drop_cnt - CW'(1) : r_drop_cnt;
      end
    end
  end
  // decode-facing registers: bubble on redirect or empty buffer, frozen while decode holds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= 32'd0;
      r_pcp4  <= 32'd4;
      r_instr <= NOP_INSTR;
      r_nop   <= 1'b1;
    end else if (redirect) begin
      r_instr <= NOP_INSTR;
      r_nop   <= 1'b1;
    end else if (!keep) begin
      r_pc    <= w_empty ? r_pc : w_head.pc;
      r_pcp4  <= w_empty ? r_pcp4 : w_head.pc + 32'd4;
      r_instr <= w_empty ? NOP_INSTR : w_head.instr;
      r_nop   <= w_empty;
    end
  end
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst)
    !(imem_rvalid && r_outstanding == '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_push && w_full && !w_pop));
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors and corner sequences against a latency-L echo memory
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        keep = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc0;
  logic [31:0] pcp4;
  logic [31:0] instr;
  logic        fnop;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;
  logic        seen_req;
  logic [31:0] seen_addr;
  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  typedef struct {
    logic        keep;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic        e_nop;
  } vec_t;
  vec_t tv[17];

  fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .keep             (keep),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .PC_pype0         (pc0),
    .PCp4_pype0       (pcp4),
    .Instraction_pype (instr),
    .fetch_nop        (fnop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_out(input string name, input logic [31:0] e_pc, input logic [31:0] e_ins,
                         input logic e_nop);
    chk({name, ".pc"}, pc0, e_pc);
    chk({name, ".pcp4"}, pcp4, e_pc + 32'd4);
    chk({name, ".instr"}, instr, e_ins);
    chk({name, ".nop"}, {31'd0, fnop}, {31'd0, e_nop});
  endtask

  // one clock cycle, entered and left at a negedge; memory echoes the address after lat cycles
  task automatic tick();
    if (mq.size() != 0 && mq[0].due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq[0].a;
      void'(mq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hdead_beef;
    end
    #1;
    seen_req  = imem_req;
    seen_addr = imem_addr;
    if (imem_req && imem_ready) mq.push_back('{imem_addr, cyc + lat});
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    keep = 1'b0;
    redirect = 1'b0;
    imem_rvalid = 1'b0;
    mq.delete();
    @(negedge clk);
    @(negedge clk);
    chk_out("reset", 32'd0, NOP, 1'b1);
    chk("reset.req", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // keep, req, addr, output pc, output instr, output nop (output seen in the following cycle)
    tv[0]  = '{1'b0, 1'b1, 32'd0,  32'd0,  NOP,    1'b1};
    tv[1]  = '{1'b0, 1'b1, 32'd4,  32'd0,  NOP,    1'b1};
    tv[2]  = '{1'b0, 1'b1, 32'd8,  32'd0,  32'd0,  1'b0};
    tv[3]  = '{1'b0, 1'b1, 32'd12, 32'd4,  32'd4,  1'b0};
    tv[4]  = '{1'b0, 1'b1, 32'd16, 32'd8,  32'd8,  1'b0};
    tv[5]  = '{1'b1, 1'b1, 32'd20, 32'd8,  32'd8,  1'b0};
    tv[6]  = '{1'b1, 1'b1, 32'd24, 32'd8,  32'd8,  1'b0};
    tv[7]  = '{1'b1, 1'b0, 32'd0,  32'd8,  32'd8,  1'b0};
    tv[8]  = '{1'b1, 1'b0, 32'd0,  32'd8,  32'd8,  1'b0};
    tv[9]  = '{1'b1, 1'b0, 32'd0,  32'd8,  32'd8,  1'b0};
    tv[10] = '{1'b0, 1'b0, 32'd0,  32'd12, 32'd12, 1'b0};
    tv[11] = '{1'b0, 1'b1, 32'd28, 32'd16, 32'd16, 1'b0};
    tv[12] = '{1'b0, 1'b1, 32'd32, 32'd20, 32'd20, 1'b0};
    tv[13] = '{1'b0, 1'b1, 32'd36, 32'd24, 32'd24, 1'b0};
    tv[14] = '{1'b0, 1'b1, 32'd40, 32'd28, 32'd28, 1'b0};
    tv[15] = '{1'b0, 1'b1, 32'd44, 32'd32, 32'd32, 1'b0};
    tv[16] = '{1'b0, 1'b1, 32'd48, 32'd36, 32'd36, 1'b0};

    // streaming at L=1 with a 5-cycle decode hold
    lat = 1;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      keep = tv[i].keep;
      tick();
      chk($sformatf("vec%0d.req", i), {31'd0, seen_req}, {31'd0, tv[i].e_req});
      if (tv[i].e_req) chk($sformatf("vec%0d.addr", i), seen_addr, tv[i].e_addr);
      chk_out($sformatf("vec%0d", i), tv[i].e_pc, tv[i].e_ins, tv[i].e_nop);
    end

    // L=3, redirect to 0x100 with two responses in flight
    lat = 3;
    do_reset();
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("l3.redir_req", {31'd0, seen_req}, 32'd0);
    chk_out("l3.c3", 32'd0, NOP, 1'b1);
    for (int c = 3; c <= 8; c++) begin
      tick();
      if (c == 3) chk("l3.addr0", seen_addr, 32'h100);
      if (c == 4) chk("l3.addr1", seen_addr, 32'h104);
      if (c < 7) chk_out($sformatf("l3.c%0d", c + 1), 32'd0, NOP, 1'b1);
      else chk_out($sformatf("l3.c%0d", c + 1), 32'h100 + 32'(4 * (c - 7)),
                   32'h100 + 32'(4 * (c - 7)), 1'b0);
    end

    // redirect to 0x203 while holding, with a response arriving in the same cycle
    lat = 1;
    do_reset();
    repeat (4) tick();
    chk_out("rk.c4", 32'd4, 32'd4, 1'b0);
    keep = 1'b1;
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h203;
    tick();
    redirect = 1'b0;
    chk("rk.redir_req", {31'd0, seen_req}, 32'd0);
    chk_out("rk.c7", 32'd4, NOP, 1'b1);
    keep = 1'b0;
    tick();
    chk("rk.addr0", seen_addr, 32'h200);
    chk_out("rk.c8", 32'd4, NOP, 1'b1);
    tick();
    chk("rk.addr1", seen_addr, 32'h204);
    chk_out("rk.c9", 32'd4, NOP, 1'b1);
    tick();
    chk_out("rk.c10", 32'h200, 32'h200, 1'b0);

    // asynchronous reset with three words buffered
    do_reset();
    repeat (4) tick();
    keep = 1'b1;
    tick();
    tick();
    chk_out("ar.pre", 32'd4, 32'd4, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_out("ar.async", 32'd0, NOP, 1'b1);
    chk("ar.req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b0;
    keep = 1'b0;
    mq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    tick();
    chk("ar.req0", {31'd0, seen_req}, 32'd1);
    chk("ar.addr0", seen_addr, 32'd0);
    chk_out("ar.c1", 32'd0, NOP, 1'b1);
    tick();
    chk_out("ar.c2", 32'd0, NOP, 1'b1);
    tick();
    chk_out("ar.c3", 32'd0, 32'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
